// File: rtl/abus_bridge_if.sv
`default_nettype none
// ============================================================================
// abus_bridge_if
// Signal bundles for abus_bridge: the cartridge-slot host bus and the
// memory-hub master port.
// Revision: 1.0 - initial release
// ============================================================================

// Host bus: the host is the master, the bridge is the slave.
interface abus_host_if;
  logic        abus_cs_n;
  logic        abus_rd_n;
  logic [1:0]  abus_wr_n;
  logic [24:0] abus_addr;
  logic [15:0] abus_din;
  logic [15:0] abus_dout;
  logic        abus_doe;
  logic        abus_wait_n;

  modport master (
    output abus_cs_n, abus_rd_n, abus_wr_n, abus_addr, abus_din,
    input  abus_dout, abus_doe, abus_wait_n
  );

  modport slave (
    input  abus_cs_n, abus_rd_n, abus_wr_n, abus_addr, abus_din,
    output abus_dout, abus_doe, abus_wait_n
  );
endinterface

// Memory hub port: the bridge is the master, the hub is the slave.
interface abus_mem_if;
  logic        mem_cs;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_mask;
  logic        mem_nwait;
  logic [25:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (
    output mem_cs, mem_rd, mem_wr, mem_mask, mem_addr, mem_wdata,
    input  mem_nwait, mem_rdata
  );

  modport slave (
    input  mem_cs, mem_rd, mem_wr, mem_mask, mem_addr, mem_wdata,
    output mem_nwait, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/abus_bridge.sv
`default_nettype none
// ============================================================================
// abus_bridge
// Host-bus to memory-hub front end: strobe synchronisers, host WAIT
// generation, read data hold, one-entry posted write buffer with
// read-after-write ordering.
// Revision: 1.0 - initial release
// ============================================================================
module abus_bridge #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [25:0] ADDR_BASE   = 26'h0000000
) (
  input  logic       clk,
  input  logic       reset,
  abus_host_if.slave host,
  abus_mem_if.master mem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WREQ = 2'd1;
  localparam logic [1:0] RREQ = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0] state;

  // Raw host strobes and their synchronised versions
  logic                   rd_act;
  logic                   wr_act;
  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic                   rd_s;
  logic                   wr_s;
  logic                   rd_s_q;
  logic                   wr_s_q;
  logic                   rd_rise;
  logic                   rd_fall;
  logic                   wr_rise;
  logic                   wr_fall;

  // Host address mapped into the memory byte space
  logic [25:0] host_byte_addr;
  logic [25:0] host_mem_addr;

  // Posted write buffer
  logic        wbuf_valid;
  logic [25:0] wbuf_addr;
  logic [15:0] wbuf_data;
  logic [1:0]  wbuf_mask;
  logic        wr_taken;
  logic        wr_defer;
  logic        wr_capture;
  logic        wbuf_drain;

  // Read tracking
  logic        rd_pend;
  logic        rd_live;
  logic        rd_done;
  logic        rd_go;
  logic        rd_issue;
  logic        rd_complete;
  logic [25:0] rd_addr;
  logic [25:0] rd_go_addr;
  logic [15:0] dout_hold;

  // Memory request registers
  logic        seen_busy;
  logic        mem_done;
  logic        req_cs;
  logic        req_rd;
  logic        req_wr;
  logic [25:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_mask;

  assign rd_act = ~host.abus_cs_n & ~host.abus_rd_n;
  assign wr_act = ~host.abus_cs_n & (host.abus_wr_n != 2'b11);

  assign rd_s    = rd_sync[SYNC_STAGES-1];
  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign rd_rise = rd_s & ~rd_s_q;
  assign rd_fall = ~rd_s & rd_s_q;
  assign wr_rise = wr_s & ~wr_s_q;
  assign wr_fall = ~wr_s & wr_s_q;

  // Offset wraps silently at 2^26; bit 0 is forced low so the result is
  // always halfword aligned even with an odd base.
  assign host_byte_addr = {host.abus_addr, 1'b0} + ADDR_BASE;
  assign host_mem_addr  = host_byte_addr & 26'h3FFFFFE;

  // A request only completes after the hub has shown at least one busy cycle
  assign mem_done    = req_cs & seen_busy & mem.mem_nwait;
  assign wbuf_drain  = (state == WREQ) & mem_done;
  assign rd_complete = (state == RREQ) & mem_done;

  // A deferred write lands on the very edge the buffer drains
  assign wr_capture = wr_s & (wr_rise | wr_defer) & (~wbuf_valid | wbuf_drain);

  // A pending read is only worth issuing while its strobe is still held
  assign rd_go      = rd_rise | (rd_pend & rd_s);
  assign rd_go_addr = rd_rise ? host_mem_addr : rd_addr;
  assign rd_issue   = (state == IDLE) & ~wbuf_valid & rd_go;

  assign host.abus_doe    = rd_act;
  assign host.abus_wait_n = ~((rd_act & ~rd_done) | (wr_act & wbuf_valid & ~wr_taken));
  assign host.abus_dout   = dout_hold;

  assign mem.mem_cs    = req_cs;
  assign mem.mem_rd    = req_rd;
  assign mem.mem_wr    = req_wr;
  assign mem.mem_addr  = req_addr;
  assign mem.mem_wdata = req_wdata;
  assign mem.mem_mask  = req_mask;

  // Bring host strobes into clk and keep one extra stage for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_sync <= '0;
      wr_sync <= '0;
      rd_s_q  <= 1'b0;
      wr_s_q  <= 1'b0;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], rd_act};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], wr_act};
      rd_s_q  <= rd_s;
      wr_s_q  <= wr_s;
    end
  end

  // Posted write buffer: capture, defer while full, drain on completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbuf_valid <= 1'b0;
      wbuf_addr  <= '0;
      wbuf_data  <= '0;
      wbuf_mask  <= '0;
      wr_taken   <= 1'b0;
      wr_defer   <= 1'b0;
    end else begin
      if (wr_capture) begin
        wbuf_addr <= host_mem_addr;
        wbuf_data <= host.abus_din;
        wbuf_mask <= host.abus_wr_n;
      end
      if (wr_capture) begin
        wbuf_valid <= 1'b1;
      end else if (wbuf_drain) begin
        wbuf_valid <= 1'b0;
      end
      if (wr_fall) begin
        wr_taken <= 1'b0;
      end else if (wr_capture) begin
        wr_taken <= 1'b1;
      end
      if (wr_capture || wr_fall) begin
        wr_defer <= 1'b0;
      end else if (wr_rise) begin
        wr_defer <= 1'b1;
      end
    end
  end

  // Read bookkeeping: pending request, ownership by the live strobe, data hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend   <= 1'b0;
      rd_live   <= 1'b0;
      rd_done   <= 1'b0;
      rd_addr   <= '0;
      dout_hold <= '0;
    end else begin
      if (rd_rise) begin
        rd_addr <= host_mem_addr;
      end
      if (rd_issue) begin
        rd_pend <= 1'b0;
      end else if (rd_rise) begin
        rd_pend <= 1'b1;
      end else if (rd_fall) begin
        rd_pend <= 1'b0;
      end
      if (rd_issue) begin
        rd_live <= 1'b1;
      end else if (rd_fall || rd_complete) begin
        rd_live <= 1'b0;
      end
      if (rd_fall) begin
        rd_done <= 1'b0;
      end else if (rd_complete && rd_live && rd_s) begin
        rd_done <= 1'b1;
      end
      if (rd_complete && rd_live && rd_s) begin
        dout_hold <= mem.mem_rdata;
      end
    end
  end

  // Request sequencer: writes take priority, then one idle gap per request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      seen_busy <= 1'b0;
      req_cs    <= 1'b0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_mask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wbuf_valid) begin
            state     <= WREQ;
            req_cs    <= 1'b1;
            req_wr    <= 1'b1;
            req_addr  <= wbuf_addr;
            req_wdata <= wbuf_data;
            req_mask  <= wbuf_mask;
          end else if (rd_go) begin
            state    <= RREQ;
            req_cs   <= 1'b1;
            req_rd   <= 1'b1;
            req_addr <= rd_go_addr;
            req_mask <= 2'b00;
          end
        end
        WREQ, RREQ: begin
          if (!mem.mem_nwait) begin
            seen_busy <= 1'b1;
          end
          if (mem_done) begin
            state     <= GAP;
            seen_busy <= 1'b0;
            req_cs    <= 1'b0;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_abus_bridge.sv
`default_nettype none
// ============================================================================
// tb_abus_bridge
// Scoreboard bench for abus_bridge: host tasks push expected memory requests
// and read data; independent monitors pop and compare.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_abus_bridge;

  typedef struct {
    logic        rd;
    logic [25:0] addr;
    logic [15:0] wdata;
    logic [1:0]  mask;
  } mreq_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  abus_host_if h();
  abus_mem_if  m();
  abus_host_if h2();
  abus_mem_if  m2();

  abus_bridge #(.SYNC_STAGES(2), .ADDR_BASE(26'h0000000)) dut (
    .clk(clk), .reset(reset), .host(h.slave), .mem(m.master)
  );

  abus_bridge #(.SYNC_STAGES(2), .ADDR_BASE(26'h3FFFFFE)) dut_wrap (
    .clk(clk), .reset(reset), .host(h2.slave), .mem(m2.master)
  );

  int tests = 0;
  int fails = 0;

  mreq_t       exp_mem[$];
  logic [15:0] exp_rd[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Memory model for the main DUT: busy for busy_cycles, byte-masked store
  logic [15:0] store [int];
  int          busy_cycles = 4;
  int          mcnt;
  int          mst;
  logic [15:0] mold;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mst         <= 0;
      mcnt        <= 0;
      m.mem_nwait <= 1'b1;
      m.mem_rdata <= 16'h0;
    end else begin
      case (mst)
        0: if (m.mem_cs) begin
             m.mem_nwait <= 1'b0;
             mcnt        <= busy_cycles;
             mst         <= 1;
           end
        1: if (mcnt <= 1) begin
             m.mem_nwait <= 1'b1;
             mst         <= 2;
             if (m.mem_wr) begin
               mold = store.exists(int'(m.mem_addr)) ? store[int'(m.mem_addr)] : 16'h0;
               if (!m.mem_mask[1]) mold[15:8] = m.mem_wdata[15:8];
               if (!m.mem_mask[0]) mold[7:0]  = m.mem_wdata[7:0];
               store[int'(m.mem_addr)] = mold;
             end else begin
               m.mem_rdata <= store.exists(int'(m.mem_addr)) ? store[int'(m.mem_addr)] : 16'hDEAD;
             end
           end else begin
             mcnt <= mcnt - 1;
           end
        default: if (!m.mem_cs) mst <= 0;
      endcase
    end
  end

  // Minimal memory model for the wrap DUT: one busy cycle, fixed data
  int mst2;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mst2         <= 0;
      m2.mem_nwait <= 1'b1;
      m2.mem_rdata <= 16'h0;
    end else begin
      case (mst2)
        0: if (m2.mem_cs) begin m2.mem_nwait <= 1'b0; mst2 <= 1; end
        1: begin m2.mem_nwait <= 1'b1; m2.mem_rdata <= 16'h5AA5; mst2 <= 2; end
        default: if (!m2.mem_cs) mst2 <= 0;
      endcase
    end
  end

  // Memory-side monitor: each new request is compared with the scoreboard
  logic  prev_cs = 1'b0;
  mreq_t e;
  always @(negedge clk) begin
    if (reset && m.mem_cs && !prev_cs) begin
      check("mem_one_cmd", {31'd0, m.mem_rd ^ m.mem_wr}, 32'd1);
      if (exp_mem.size() == 0) begin
        check("mem_unexpected_req", {6'd0, m.mem_addr}, 32'hFFFFFFFF);
      end else begin
        e = exp_mem.pop_front();
        check("mem_kind_rd", {31'd0, m.mem_rd}, {31'd0, e.rd});
        check("mem_addr", {6'd0, m.mem_addr}, {6'd0, e.addr});
        if (!e.rd) begin
          check("mem_wdata", {16'd0, m.mem_wdata}, {16'd0, e.wdata});
          check("mem_mask", {30'd0, m.mem_mask}, {30'd0, e.mask});
        end
      end
    end
    prev_cs = m.mem_cs;
  end

  // Host-side monitor: read data is checked when WAIT releases during a read
  logic prev_pres = 1'b0;
  logic pres;
  always @(negedge clk) begin
    pres = h.abus_doe & h.abus_wait_n;
    if (pres && !prev_pres) begin
      if (exp_rd.size() == 0) check("host_unexpected_data", {16'd0, h.abus_dout}, 32'hFFFFFFFF);
      else check("host_rdata", {16'd0, h.abus_dout}, {16'd0, exp_rd.pop_front()});
    end
    prev_pres = pres;
  end

  task automatic host_read(input logic [24:0] a, input logic [25:0] exp_addr, input logic [15:0] exp_data);
    mreq_t r;
    int n, waited;
    r.rd = 1'b1; r.addr = exp_addr; r.wdata = 16'h0; r.mask = 2'b00;
    exp_mem.push_back(r);
    exp_rd.push_back(exp_data);
    @(posedge clk); #1;
    h.abus_addr = a; h.abus_cs_n = 1'b0; h.abus_rd_n = 1'b0;
    n = 0; waited = 0;
    do begin
      @(negedge clk);
      if (!h.abus_wait_n) waited++;
      n++;
    end while (!h.abus_wait_n && n < 300);
    check("rd_wait_release", {31'd0, h.abus_wait_n}, 32'd1);
    check("rd_wait_seen", {31'd0, waited > 0}, 32'd1);
    @(posedge clk); #1;
    h.abus_cs_n = 1'b1; h.abus_rd_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic host_write(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be_n,
                            input logic [25:0] exp_addr, input logic expect_wait);
    mreq_t r;
    int n, waited;
    r.rd = 1'b0; r.addr = exp_addr; r.wdata = d; r.mask = be_n;
    exp_mem.push_back(r);
    @(posedge clk); #1;
    h.abus_addr = a; h.abus_din = d; h.abus_wr_n = be_n; h.abus_cs_n = 1'b0;
    n = 0; waited = 0;
    do begin
      @(negedge clk);
      if (!h.abus_wait_n) waited++;
      n++;
    end while (!h.abus_wait_n && n < 300);
    check("wr_wait_release", {31'd0, h.abus_wait_n}, 32'd1);
    check("wr_wait_seen", {31'd0, waited > 0}, {31'd0, expect_wait});
    repeat (4) begin
      @(negedge clk);
      check("wr_wait_hold", {31'd0, h.abus_wait_n}, 32'd1);
    end
    @(posedge clk); #1;
    h.abus_cs_n = 1'b1; h.abus_wr_n = 2'b11;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mreq_t r;
    h.abus_cs_n = 1'b1; h.abus_rd_n = 1'b1; h.abus_wr_n = 2'b11; h.abus_addr = '0; h.abus_din = '0;
    h2.abus_cs_n = 1'b1; h2.abus_rd_n = 1'b1; h2.abus_wr_n = 2'b11; h2.abus_addr = '0; h2.abus_din = '0;
    store[32'h20] = 16'hA55A;
    store[32'h42] = 16'h7777;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_mem_cs", {31'd0, m.mem_cs}, 32'd0);
    check("reset_mem_mask", {30'd0, m.mem_mask}, 32'd0);
    check("reset_mem_addr", {6'd0, m.mem_addr}, 32'd0);
    check("reset_dout", {16'd0, h.abus_dout}, 32'd0);
    check("reset_wait_n", {31'd0, h.abus_wait_n}, 32'd1);
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // Single read, 4 busy cycles
    busy_cycles = 4;
    host_read(25'h0000010, 26'h20, 16'hA55A);

    // Posted write, upper byte masked
    host_write(25'h3, 16'h1234, 2'b10, 26'h6, 1'b0);
    repeat (20) @(posedge clk);

    // Back-to-back writes against a slow memory
    busy_cycles = 10;
    host_write(25'h40, 16'h1111, 2'b00, 26'h80, 1'b0);
    host_write(25'h41, 16'h2222, 2'b01, 26'h82, 1'b1);
    repeat (40) @(posedge clk);

    // Read-after-write to the same address
    host_write(25'h8, 16'hBEEF, 2'b00, 26'h10, 1'b0);
    host_read(25'h8, 26'h10, 16'hBEEF);

    // Base wrap on the second instance
    @(posedge clk); #1;
    h2.abus_addr = 25'h1; h2.abus_cs_n = 1'b0; h2.abus_rd_n = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!m2.mem_cs && n < 100);
    check("wrap_req_seen", {31'd0, m2.mem_cs}, 32'd1);
    check("wrap_addr", {6'd0, m2.mem_addr}, 32'd0);
    check("wrap_is_read", {30'd0, m2.mem_rd, m2.mem_wr}, 32'd2);
    n = 0;
    do begin @(negedge clk); n++; end while (!h2.abus_wait_n && n < 100);
    check("wrap_wait_release", {31'd0, h2.abus_wait_n}, 32'd1);
    check("wrap_rdata", {16'd0, h2.abus_dout}, 32'h5AA5);
    @(posedge clk); #1;
    h2.abus_cs_n = 1'b1; h2.abus_rd_n = 1'b1;
    repeat (5) @(posedge clk);

    // Asynchronous reset in the middle of a read request
    busy_cycles = 10;
    r.rd = 1'b1; r.addr = 26'h40; r.wdata = 16'h0; r.mask = 2'b00;
    exp_mem.push_back(r);
    @(posedge clk); #1;
    h.abus_addr = 25'h20; h.abus_cs_n = 1'b0; h.abus_rd_n = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!m.mem_cs && n < 100);
    check("rst_req_seen", {31'd0, m.mem_cs}, 32'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mem_cs", {31'd0, m.mem_cs}, 32'd0);
    check("rst_mem_rd", {31'd0, m.mem_rd}, 32'd0);
    check("rst_dout", {16'd0, h.abus_dout}, 32'd0);
    check("rst_wbuf_valid", {31'd0, dut.wbuf_valid}, 32'd0);
    h.abus_cs_n = 1'b1; h.abus_rd_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // Fresh read after reset release
    busy_cycles = 4;
    host_read(25'h21, 26'h42, 16'h7777);

    repeat (20) @(posedge clk);
    check("mem_queue_empty", exp_mem.size(), 32'd0);
    check("rd_queue_empty", exp_rd.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
